// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Opcode and immediate-select constants shared by the front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  imm_sel;
    } fetch_entry_t;

    // Opcodes with no immediate (e.g. R-type) fall back to the I encoding.
    function automatic logic [2:0] predecode_imm_sel(input logic [6:0] opcode);
        logic [2:0] sel;
        sel = IMM_I;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: sel = IMM_I;
            OPC_STORE:                                  sel = IMM_S;
            OPC_BRANCH:                                 sel = IMM_B;
            OPC_LUI, OPC_AUIPC:                         sel = IMM_U;
            OPC_JAL:                                    sel = IMM_J;
            default:                                    sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH x WIDTH synchronous FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 67
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (count_q == c_depth);
    assign empty_o = (count_q == '0);
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~w_full | w_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front-end with IMEM request, buffer, predecode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit import riscv_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [2:0]  dec_imm_sel
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] c_depth = DEPTH[OW-1:0];

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         w_pop;
    logic         w_push;
    logic         w_empty;
    logic [CW-1:0] w_count;
    logic [OW-1:0] w_occupancy;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head_entry;

    assign w_pop = dec_valid & dec_ready;
    // Slots already committed after this cycle's pop; requests stop at DEPTH.
    assign w_occupancy = OW'(w_count) + OW'(inflight_q) - OW'(w_pop);

    always_comb begin
        imem_addr     = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : fetch_pc_q;
        imem_req      = rst & (redirect_valid | (w_occupancy < c_depth));
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (imem_req) begin
            fetch_pc_d    = imem_addr + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = imem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A redirect this cycle kills the response of the previous cycle's request.
    assign w_push = inflight_q & ~redirect_valid;
    assign w_push_entry = '{inst:    imem_rdata,
                            pc:      inflight_pc_q,
                            imm_sel: predecode_imm_sel(imem_rdata[6:0])};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .rdata_o (w_head_entry),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign dec_valid   = ~w_empty;
    assign dec_inst    = dec_valid ? w_head_entry.inst    : '0;
    assign dec_pc      = dec_valid ? w_head_entry.pc      : '0;
    assign dec_imm_sel = dec_valid ? w_head_entry.imm_sel : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with an IMEM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h4000_0000;
    localparam logic [31:0] TBL_BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [2:0]  dec_imm_sel;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_imm_sel    (dec_imm_sel)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
    } vec_t;

    vec_t        vecs [6];
    logic [6:0]  opc_pool [16];

    int          nchk = 0;
    int          nerr = 0;
    int          since;
    int          stall_run;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] prev_addr;
    logic        prev_req;

    function automatic logic [31:0] mem(input logic [31:0] pc);
        logic [31:0] h;
        int idx;
        if (pc >= TBL_BASE && pc < TBL_BASE + 32'd24) begin
            idx = int'((pc - TBL_BASE) >> 2);
            return vecs[idx].inst;
        end
        h = (pc * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return {h[31:7], opc_pool[pc[5:2]]};
    endfunction

    function automatic logic [2:0] ref_sel(input logic [31:0] inst);
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return 3'd0;
            7'b0100011:                                     return 3'd1;
            7'b1100011:                                     return 3'd2;
            7'b0110111, 7'b0010111:                         return 3'd3;
            7'b1101111:                                     return 3'd4;
            default:                                        return 3'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        since     = -1;
        stall_run = 0;
        exp_pc    = RST_PC;
        exp_fetch = RST_PC;
        prev_req  = 1'b0;
        prev_addr = '0;
    endtask

    // One clock cycle: drive, sample mid-cycle, check, then advance the model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] raddr;
        logic        exp_valid;
        @(posedge clk);
        #1;
        rst            = 1'b1;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = prev_req ? mem(prev_addr) : $urandom();
        #3;
        exp_valid = (since >= 1);
        check("dec_valid", 32'(dec_valid), 32'(exp_valid));
        if (dec_valid && exp_valid) begin
            check("dec_pc", dec_pc, exp_pc);
            check("dec_inst", dec_inst, mem(exp_pc));
            check("dec_imm_sel", 32'(dec_imm_sel), 32'(ref_sel(mem(exp_pc))));
        end
        raddr     = rpc & 32'hFFFF_FFFC;
        stall_run = (!rdy && !rv) ? stall_run + 1 : 0;
        if (rv) begin
            check("imem_req_redirect", 32'(imem_req), 32'd1);
            check("imem_addr_redirect", imem_addr, raddr);
        end else begin
            if (rdy) check("imem_req_ready", 32'(imem_req), 32'd1);
            if (stall_run >= 3) check("imem_req_stall", 32'(imem_req), 32'd0);
            if (imem_req) check("imem_addr", imem_addr, exp_fetch);
        end
        if (imem_req) exp_fetch = (rv ? raddr : exp_fetch) + 32'd4;
        if (rv) begin
            exp_pc = raddr;
            since  = 0;
        end else begin
            if (dec_valid && exp_valid && rdy) exp_pc = exp_pc + 32'd4;
            if (since < 8) since++;
        end
        prev_req  = imem_req;
        prev_addr = imem_addr;
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        imem_rdata     = prev_req ? mem(prev_addr) : $urandom();
        #1;
        check("rst_mid_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_mid_imem_req", 32'(imem_req), 32'd0);
        check("rst_mid_dec_pc", dec_pc, 32'd0);
        repeat (2) @(posedge clk);
        #4;
        check("rst_hold_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_hold_dec_inst", dec_inst, 32'd0);
        model_reset();
    endtask

    initial begin
        vecs[0] = '{inst: 32'h0000_0013, sel: 3'b000};
        vecs[1] = '{inst: 32'h0000_2023, sel: 3'b001};
        vecs[2] = '{inst: 32'h0000_0063, sel: 3'b010};
        vecs[3] = '{inst: 32'h0000_00B7, sel: 3'b011};
        vecs[4] = '{inst: 32'h0000_006F, sel: 3'b100};
        vecs[5] = '{inst: 32'h0000_0033, sel: 3'b000};
        opc_pool = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                     7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                     7'b1101111, 7'b0110011, 7'b0001111, 7'b0101111,
                     7'b0000000, 7'b1111111, 7'b1010011, 7'b0111011};

        rst            = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        #2;
        check("reset_dec_valid", 32'(dec_valid), 32'd0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_dec_inst", dec_inst, 32'd0);
        check("reset_dec_pc", dec_pc, 32'd0);
        check("reset_dec_imm_sel", 32'(dec_imm_sel), 32'd0);
        model_reset();

        // Release, then stall with the head at the reset PC.
        step(1'b1, 1'b0, '0);
        check("first_imem_addr", imem_addr, 32'h4000_0000);
        step(1'b1, 1'b0, '0);
        check("second_imem_addr", imem_addr, 32'h4000_0004);
        repeat (5) step(1'b0, 1'b0, '0);
        check("stall_head_pc", dec_pc, 32'h4000_0000);
        check("stall_no_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, '0);
        check("release_imem_addr", imem_addr, 32'h4000_0008);

        // Redirect while popping 0x4000_0004.
        step(1'b1, 1'b1, 32'h3000_0000);
        check("pop_with_redirect_pc", dec_pc, 32'h4000_0004);
        repeat (4) step(1'b1, 1'b0, '0);

        // Redirect to a misaligned target with a fetch in flight.
        step(1'b1, 1'b1, 32'h1000_0006);
        check("redirect_addr_aligned", imem_addr, 32'h1000_0004);
        step(1'b1, 1'b0, '0);
        check("redirect_bubble", 32'(dec_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        check("redirect_first_pc", dec_pc, 32'h1000_0004);
        step(1'b1, 1'b0, '0);
        check("redirect_second_pc", dec_pc, 32'h1000_0008);

        // Predecode vectors.
        step(1'b1, 1'b1, TBL_BASE);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, '0);
            check("tbl_pc", dec_pc, TBL_BASE + 32'(4 * i));
            check("tbl_inst", dec_inst, vecs[i].inst);
            check("tbl_imm_sel", 32'(dec_imm_sel), 32'(vecs[i].sel));
        end

        // Address wrap at the top of the space.
        step(1'b1, 1'b1, 32'hFFFF_FFFB);
        repeat (3) step(1'b1, 1'b0, '0);
        check("wrap_pc_top", dec_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        check("wrap_pc_zero", dec_pc, 32'h0000_0000);

        // Randomized traffic against the stream model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 $urandom());
        end

        // Asynchronous reset with a full buffer.
        step(1'b1, 1'b0, '0);
        repeat (4) step(1'b0, 1'b0, '0);
        reset_mid();
        step(1'b1, 1'b0, '0);
        check("restart_imem_addr", imem_addr, RST_PC);
        repeat (3) step(1'b1, 1'b0, '0);
        check("restart_dec_pc", dec_pc, 32'h4000_0004);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
